// File: rtl/merge_pkg.sv
// Shared types and default sizing for the result merger.
package merge_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_NUM_LANE     = 2;
    localparam int DEF_BURST_LENGTH = 32;
    localparam int DEF_DEPTH        = 2 * DEF_BURST_LENGTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        TAIL  = 2'd2
    } state_t;

endpackage

// File: rtl/merge_fifo.sv
// Word FIFO with first-word-fall-through head; push lands next edge, head visible same cycle.
// Push while full and pop while empty are ignored; caller gates with full/empty.
module merge_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer = {wrap, index}; index wraps at DEPTH so non-power-of-two depths work.
    function automatic logic [AW:0] bump(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        else
            return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= bump(wr_ptr);
            if (pop && !empty)
                rd_ptr <= bump(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    always_comb begin
        if (wr_ptr[AW] == rd_ptr[AW])
            count = CW'(wr_ptr[AW-1:0]) - CW'(rd_ptr[AW-1:0]);
        else
            count = CW'(DEPTH) - CW'(rd_ptr[AW-1:0]) + CW'(wr_ptr[AW-1:0]);
    end

endmodule

// File: rtl/merge.sv
// Packs result elements into NUM_LANE-wide words and writes them back in fixed bursts plus a flush tail.
// dout falls through from the FIFO head; in_ready drops when full or a flush is pending.
module merge
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_LANE     = DEF_NUM_LANE,
    parameter int BURST_LENGTH = DEF_BURST_LENGTH,
    parameter int DEPTH        = 2 * BURST_LENGTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANE*DATA_WIDTH-1:0] dout,
    output logic                         out_last,
    output logic                         flush_done,
    output logic                         full_flag,
    output logic                         empty_flag,
    output logic [CW-1:0]                word_count
);

    localparam int WW = NUM_LANE * DATA_WIDTH;
    localparam int LW = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
    localparam int BW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [LW-1:0]   lane_cnt;
    logic [WW-1:0]   lane_buf;
    logic [WW-1:0]   fill_word;
    logic [WW-1:0]   push_dat;
    logic            flush_pending;
    logic            run;
    logic            accept;
    logic            pad;
    logic            push;
    logic            pop;

    assign in_ready = run && !full_flag && !flush_pending;
    assign accept   = in_valid && in_ready;
    assign pad      = flush_pending && (lane_cnt != '0) && !full_flag;
    assign push     = (accept && (lane_cnt == LW'(NUM_LANE - 1))) || pad;
    assign pop      = out_valid && out_ready;

    // Unfilled lanes of lane_buf are always zero, so a flush pad pushes it as-is.
    always_comb begin
        fill_word = lane_buf;
        for (int i = 0; i < NUM_LANE; i++) begin
            if (LW'(i) == lane_cnt)
                fill_word[i*DATA_WIDTH +: DATA_WIDTH] = din;
        end
    end

    assign push_dat   = pad ? lane_buf : fill_word;
    assign flush_done = flush_pending && (state == IDLE) && (lane_cnt == '0) && empty_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run           <= 1'b0;
            lane_cnt      <= '0;
            lane_buf      <= '0;
            flush_pending <= 1'b0;
        end else begin
            run <= 1'b1;
            if (push) begin
                lane_cnt <= '0;
                lane_buf <= '0;
            end else if (accept) begin
                lane_cnt <= lane_cnt + LW'(1);
                lane_buf <= fill_word;
            end
            if (flush_done)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (word_count >= CW'(BURST_LENGTH)) begin
                        state     <= BURST;
                        out_valid <= 1'b1;
                        out_last  <= (BURST_LENGTH == 1);
                    end else if (flush_pending && (lane_cnt == '0) && (word_count != '0)) begin
                        state     <= TAIL;
                        out_valid <= 1'b1;
                        out_last  <= (word_count == CW'(1));
                    end
                end
                BURST: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            beat      <= '0;
                        end else begin
                            beat     <= beat + BW'(1);
                            out_last <= (beat == BW'(BURST_LENGTH - 2));
                        end
                    end
                end
                TAIL: begin
                    // No pushes happen here: the frame is closed and padded before TAIL.
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_last <= (word_count == CW'(2));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    merge_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (dout),
        .count    (word_count),
        .full     (full_flag),
        .empty    (empty_flag)
    );

endmodule

// File: tb/tb_merge.sv
// Directed bench for merge at default sizing (32-bit elements, 2 lanes, 32-beat bursts, 64-word FIFO).
module tb_merge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] dout;
    logic        out_last;
    logic        flush_done;
    logic        full_flag;
    logic        empty_flag;
    logic [6:0]  word_count;

    merge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .out_last   (out_last),
        .flush_done (flush_done),
        .full_flag  (full_flag),
        .empty_flag (empty_flag),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int fd_cyc   = 0;
    int last_cyc = 0;
    int ov_cnt   = 0;
    logic [63:0] got_dat [$];
    logic        got_last [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Log what the DUT presents now (handshakes at the coming edge), then advance one cycle.
    task automatic tick();
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            got_dat.push_back(dout);
            got_last.push_back(out_last);
            if (out_last) last_cyc = cyc;
        end
        if (flush_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int first, input int n);
        int sent = 0;
        int budget = 0;
        while (sent < n && budget < 2000) begin
            in_valid = 1'b1;
            din      = 32'(first + sent);
            if (in_ready) sent++;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        chk("send_cnt", 64'(sent), 64'(n));
    endtask

    task automatic collect(input int n, input int budget);
        int b = 0;
        while (got_dat.size() < n && b < budget) begin
            tick();
            b++;
        end
    endtask

    // Word k of a stream 1,2,3,... is {2k+2, 2k+1}; every 32nd word closes a burst.
    task automatic check_stream(input string tag, input int n);
        logic [63:0] e;
        chk({tag, "_beats"}, 64'(got_dat.size()), 64'(n));
        for (int k = 0; k < n && k < got_dat.size(); k++) begin
            e = {32'(2*k + 2), 32'(2*k + 1)};
            chk({tag, "_dat"}, got_dat[k], e);
            chk({tag, "_last"}, 64'(got_last[k]), 64'((k % 32) == 31));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int fcyc;
        logic prev_stall;
        logic [63:0] prev_dat;
        logic prev_last;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_full", 64'(full_flag), 64'(0));
        chk("rst_empty", 64'(empty_flag), 64'(1));
        chk("rst_count", 64'(word_count), 64'(0));
        chk("rst_flush_done", 64'(flush_done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One full burst from 64 elements
        out_ready = 1'b1;
        send(1, 64);
        collect(32, 300);
        repeat (5) tick();
        check_stream("t1", 32);
        chk("t1_empty", 64'(empty_flag), 64'(1));
        chk("t1_count", 64'(word_count), 64'(0));

        // Short frame closed by flush
        got_dat.delete();
        got_last.delete();
        fd_cnt = 0;
        send(1, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        collect(3, 100);
        repeat (4) tick();
        chk("t2_beats", 64'(got_dat.size()), 64'(3));
        if (got_dat.size() == 3) begin
            chk("t2_w0", got_dat[0], {32'd2, 32'd1});
            chk("t2_w1", got_dat[1], {32'd4, 32'd3});
            chk("t2_w2", got_dat[2], {32'd0, 32'd5});
            chk("t2_last0", 64'(got_last[0]), 64'(0));
            chk("t2_last1", 64'(got_last[1]), 64'(0));
            chk("t2_last2", 64'(got_last[2]), 64'(1));
        end
        chk("t2_fd_pulses", 64'(fd_cnt), 64'(1));
        chk("t2_fd_delay", 64'(fd_cyc - last_cyc), 64'(1));
        chk("t2_in_ready", 64'(in_ready), 64'(1));

        // Fill to capacity with the writer stalled, then drain
        got_dat.delete();
        got_last.delete();
        out_ready = 1'b0;
        send(1, 128);
        chk("t3_full", 64'(full_flag), 64'(1));
        chk("t3_count", 64'(word_count), 64'(64));
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        din      = 32'd999;
        repeat (5) tick();
        chk("t3_in_ready_hold", 64'(in_ready), 64'(0));
        chk("t3_count_hold", 64'(word_count), 64'(64));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect(64, 400);
        repeat (5) tick();
        check_stream("t3", 64);
        chk("t3_empty", 64'(empty_flag), 64'(1));

        // Burst with out_ready toggling every cycle
        got_dat.delete();
        got_last.delete();
        out_ready = 1'b0;
        send(1, 64);
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        b = 0;
        while (got_dat.size() < 32 && b < 300) begin
            out_ready = ~out_ready;
            if (prev_stall) begin
                chk("t4_stall_valid", 64'(out_valid), 64'(1));
                chk("t4_stall_dat", dout, prev_dat);
                chk("t4_stall_last", 64'(out_last), 64'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = dout;
            prev_last  = out_last;
            tick();
            b++;
        end
        out_ready = 1'b1;
        repeat (5) tick();
        check_stream("t4", 32);
        chk("t4_empty", 64'(empty_flag), 64'(1));

        // Reset in the middle of a burst
        got_dat.delete();
        got_last.delete();
        send(1, 64);
        b = 0;
        while (got_dat.size() < 10 && b < 200) begin
            tick();
            b++;
        end
        chk("t5_pre_beats", 64'(got_dat.size()), 64'(10));
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_empty", 64'(empty_flag), 64'(1));
        chk("t5_count", 64'(word_count), 64'(0));
        chk("t5_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_dat.delete();
        got_last.delete();
        send(1, 64);
        collect(32, 300);
        repeat (5) tick();
        check_stream("t5", 32);

        // Flush with nothing buffered
        got_dat.delete();
        got_last.delete();
        fd_cnt = 0;
        ov_cnt = 0;
        fcyc   = cyc;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("t6_fd_pulses", 64'(fd_cnt), 64'(1));
        chk("t6_fd_latency", 64'((fd_cyc - fcyc) <= 2), 64'(1));
        chk("t6_no_valid", 64'(ov_cnt), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/merge.md
MERGE -- requirements
Module: merge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of one result element.
REQ-002 The block SHALL have parameter NUM_LANE, default 2, elements packed per output word.
REQ-003 The block SHALL have parameter BURST_LENGTH, default 32, output words per write-back burst.
REQ-004 The block SHALL have parameter DEPTH, default 2*BURST_LENGTH, word capacity of the internal FIFO.
REQ-005 The block SHALL have ports, one clock, reset asynchronous active-low:
 clk  in  1  clock, all state on rising edge.
 rst_n  in  1  asynchronous active-low reset.
 in_valid  in  1  din carries a result element.
 in_ready  out  1  block accepts an element this cycle.
 din  in  DATA_WIDTH  result element from the compute array.
 flush  in  1  one-cycle pulse, end of frame.
 out_valid  out  1  dout holds a write-back word.
 out_ready  in  1  DMA writer accepts dout.
 dout  out  NUM_LANE x DATA_WIDTH  packed word, lane 0 = earliest element.
 out_last  out  1  final beat of the current burst.
 flush_done  out  1  one-cycle pulse, flush complete.
 full_flag  out  1  FIFO holds DEPTH words.
 empty_flag  out  1  FIFO holds 0 words.
 word_count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-006 An element SHALL be accepted only on in_valid && in_ready; in_ready = !full_flag && !flush_pending.
REQ-007 Accepted elements SHALL fill lanes 0..NUM_LANE-1 in order via a lane counter; acceptance into lane NUM_LANE-1 SHALL write the completed word into the FIFO at that same edge and reset the lane counter to 0.
REQ-008 The FIFO SHALL use read/write pointers with one extra wrap bit; full = pointers equal except wrap bit, empty = pointers equal; pointers wrap modulo DEPTH.
REQ-009 dout SHALL be first-word-fall-through from the FIFO head; a pop occurs on out_valid && out_ready.
REQ-010 Simultaneous push and pop SHALL leave word_count unchanged; a push at full SHALL be impossible because in_ready is low.
REQ-011 The burst FSM SHALL have states IDLE, BURST, TAIL, with a beat counter of clog2(BURST_LENGTH) bits.
REQ-012 IDLE -> BURST when word_count >= BURST_LENGTH; IDLE -> TAIL when flush_pending, lane counter 0, and 0 < word_count < BURST_LENGTH; out_valid = 0 in IDLE.
REQ-013 In BURST, out_valid = 1 for exactly BURST_LENGTH beats; out_last = 1 on beat BURST_LENGTH-1; after that handshake the FSM returns to IDLE.
REQ-014 In TAIL, the FSM SHALL emit all remaining words, out_last on the final one, then return to IDLE.
REQ-015 out_valid, dout and out_last SHALL remain stable while out_valid && !out_ready.
REQ-016 flush SHALL set flush_pending; an element accepted in the same cycle as flush belongs to the frame.
REQ-017 With flush_pending and lane counter nonzero, the next cycle SHALL zero-fill the remaining lanes and push the word; FIFO full delays this until space exists.
REQ-018 Full bursts SHALL drain before TAIL; when FSM is IDLE, lane counter 0 and FIFO empty with flush_pending, flush_done SHALL pulse one cycle and flush_pending SHALL clear.
REQ-019 flush while flush_pending is already set SHALL be ignored.

Reset
REQ-020 While rst_n = 0: pointers, lane counter, beat counter = 0; FSM = IDLE; flush_pending, out_valid, out_last, flush_done, full_flag, in_ready = 0; empty_flag = 1; word_count = 0.
REQ-021 Reset assertion mid-burst SHALL abort immediately, discarding FIFO and partial-word contents.

Structure
REQ-022 Package merge_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-023 The FIFO SHALL be the sub-module merge_fifo (push, pop, count, full, empty); packer and FSM stay in merge.

Verification
REQ-024 64 elements 1..64, out_ready = 1 -> one burst of 32 words, word k = {lane0 = 2k+1, lane1 = 2k+2}, out_last on word 31 only.
REQ-025 5 elements 1..5 then flush -> 3 words {1,2},{3,4},{5,0}, out_last on third, flush_done one cycle later.
REQ-026 out_ready = 0 while 128 elements are offered -> in_ready low after 64 words, full_flag = 1, word_count = 64, no data loss once out_ready = 1.
REQ-027 out_ready toggling every cycle during a burst -> dout/out_last stable across stalls, 32 beats total.
REQ-028 rst_n low at beat 10 of a burst -> out_valid = 0 and empty_flag = 1 immediately; a later 64-element frame bursts correctly.
REQ-029 flush with FIFO empty and lane counter 0 -> no out_valid, flush_done pulses within 2 cycles.
